// File: rtl/led_buf_pkg.sv
// Shared definitions for the LED line-buffer ping-pong controllers.
package led_buf_pkg;

    // Default geometry of one colour-channel line store
    localparam int LED_ADDR_WIDTH = 7;
    localparam int LED_DATA_WIDTH = 60;
    localparam int LED_LINE_LEN   = 64;

    // Per-bank address width; the bank select sits above it
    localparam int BANK_AW = LED_ADDR_WIDTH - 1;

    // Read-side sequencing: issue address, wait for RAM, present word
    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_HOLD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/led_line_pp_ctrl_if.sv
// Producer and consumer stream signals of the ping-pong line controller.
interface led_line_pp_ctrl_if
    import led_buf_pkg::*;
#(
    parameter int DATA_WIDTH = LED_DATA_WIDTH
) ();

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  out_last;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Controller side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/led_line_pp_ctrl_flags.sv
// Two-bank line-complete flags with independent set and clear requests.
// The writer only sets a non-full bank and the reader only clears a full
// bank, so both requests never address the same bank in one cycle.
module pp_bank_flags (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_set_en,
    input  logic       i_set_bank,
    input  logic       i_clr_en,
    input  logic       i_clr_bank,
    output logic [1:0] o_full
);

    logic [1:0] r_full;

    // Apply set and clear requests; both may land in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (i_set_en && (i_set_bank == b[0])) begin
                    r_full[b] <= 1'b1;
                end else if (i_clr_en && (i_clr_bank == b[0])) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    assign o_full = r_full;

endmodule

// File: rtl/led_line_pp_ctrl.sv
// Ping-pong line-buffer controller: the producer fills one RAM bank while
// the LED serializer drains the other; banks swap on complete lines only.
module led_line_pp_ctrl
    import led_buf_pkg::*;
#(
    parameter int ADDR_WIDTH = LED_ADDR_WIDTH,
    parameter int DATA_WIDTH = LED_DATA_WIDTH,
    parameter int LINE_LEN   = LED_LINE_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    led_line_pp_ctrl_if.slave     bus,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [1:0]            bank_full
);

    localparam int             CNT_W    = ADDR_WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_LEN - 1);

    // Write side state
    logic                  r_wr_bank;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_set_vld_p0;
    logic                  r_set_bank_p0;
    logic                  r_set_vld_p1;
    logic                  r_set_bank_p1;

    // Read side state
    rd_state_t             r_state;
    logic                  r_rd_bank;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_out_valid;
    logic                  r_out_last;

    logic [1:0]            w_full;
    logic                  w_in_ready;
    logic                  w_wr_hs;
    logic                  w_clr_en;

    assign w_in_ready = !w_full[r_wr_bank] && !rst;
    assign w_wr_hs    = bus.in_valid && w_in_ready;
    assign w_clr_en   = (r_state == RD_HOLD) && bus.out_ready && r_out_last;

    // Register accepted words toward the RAM and advance the fill pointer;
    // the line-complete flag trails the last RAM write by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_set_vld_p0  <= 1'b0;
            r_set_bank_p0 <= 1'b0;
            r_set_vld_p1  <= 1'b0;
            r_set_bank_p1 <= 1'b0;
        end else begin
            r_wr_en       <= w_wr_hs;
            r_set_vld_p0  <= w_wr_hs && (r_wr_cnt == LAST_CNT);
            r_set_bank_p0 <= r_wr_bank;
            r_set_vld_p1  <= r_set_vld_p0;
            r_set_bank_p1 <= r_set_bank_p0;
            if (w_wr_hs) begin
                r_wr_addr <= {r_wr_bank, r_wr_cnt};
                r_wr_data <= bus.in_data;
                if (r_wr_cnt == LAST_CNT) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

    pp_bank_flags u_flags (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (r_set_vld_p1),
        .i_set_bank (r_set_bank_p1),
        .i_clr_en   (w_clr_en),
        .i_clr_bank (r_rd_bank),
        .o_full     (w_full)
    );

    // Drain a full bank one word per two cycles, holding the address so the
    // RAM output stays stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RD_IDLE;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (w_full[r_rd_bank]) begin
                        r_rd_addr <= {r_rd_bank, r_rd_cnt};
                        r_state   <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rd_cnt == LAST_CNT);
                    r_state     <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_rd_cnt  <= '0;
                            r_rd_bank <= ~r_rd_bank;
                            r_state   <= RD_IDLE;
                        end else begin
                            r_rd_cnt  <= r_rd_cnt + 1'b1;
                            r_rd_addr <= {r_rd_bank, r_rd_cnt + 1'b1};
                            r_state   <= RD_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_data  = ram_rd_data;
    assign ram_wr_en     = r_wr_en;
    assign ram_wr_addr   = r_wr_addr;
    assign ram_wr_data   = r_wr_data;
    assign ram_rd_addr   = r_rd_addr;
    assign bank_full     = w_full;

endmodule
